// File: rtl/color_cfg_pkg.sv
//------------------------------------------------------------------------------
// Module  : color_cfg_pkg
// Brief   : Shared types and constants for the colour-config write scheduler.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package color_cfg_pkg;

    localparam int DEF_AW    = 4;
    localparam int DEF_DW    = 4;
    localparam int BURST_MAX = 8;
    localparam int BURST_W   = $clog2(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/color_cfg_scheduler_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first set req at or after ptr.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any,
    output logic [PW-1:0]   idx
);

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/color_cfg_scheduler.sv
//------------------------------------------------------------------------------
// Module  : color_cfg_scheduler
// Brief   : Round-robin four-phase write scheduler with locked bursts and timeout.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module color_cfg_scheduler
    import color_cfg_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  err,
    output logic [AW-1:0]    address,
    output logic [DW-1:0]    data,
    output logic             valid,
    input  logic             ack,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_idx;
    logic [7:0]         r_cnt;
    logic [BURST_W-1:0] r_burst;
    logic               r_held;

    logic [NREQ-1:0]    w_pick;
    logic               w_any;
    logic [PW-1:0]      w_pick_idx;
    logic [AW-1:0]      w_win_addr;
    logic [DW-1:0]      w_win_data;
    logic               w_win_req;
    logic               w_win_lock;
    logic               w_keep;
    logic               w_timeout;
    logic [PW-1:0]      w_next_ptr;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req  (req),
        .ptr  (r_ptr),
        .gnt  (w_pick),
        .any  (w_any),
        .idx  (w_pick_idx)
    );

    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        w_win_req  = 1'b0;
        w_win_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_idx == PW'(i)) begin
                w_win_addr = req_addr[i*AW +: AW];
                w_win_data = req_data[i*DW +: DW];
                w_win_req  = req[i];
                w_win_lock = lock[i];
            end
        end
    end

    // r_burst counts writes already completed in this grant minus one
    assign w_keep     = w_win_req && w_win_lock && (r_burst != BURST_W'(BURST_MAX - 1));
    assign w_timeout  = (r_cnt == 8'(TIMEOUT - 1));
    assign w_next_ptr = (r_idx == PW'(NREQ - 1)) ? '0 : r_idx + PW'(1);
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_held  <= 1'b0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            address <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        gnt     <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_burst <= '0;
                        r_held  <= 1'b0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A lingering ack from the previous write delays the strobe once
                    if (ack && !r_held) begin
                        r_held <= 1'b1;
                    end else begin
                        r_held  <= 1'b0;
                        address <= w_win_addr;
                        data    <= w_win_data;
                        valid   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack) begin
                        valid   <= 1'b0;
                        done    <= gnt;
                        r_cnt   <= '0;
                        r_state <= WAIT_LOW;
                    end else if (w_timeout) begin
                        valid   <= 1'b0;
                        err     <= gnt;
                        r_cnt   <= '0;
                        r_state <= WAIT_LOW;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!ack || w_timeout) begin
                        r_cnt <= '0;
                        if (w_keep) begin
                            r_burst <= r_burst + 1'b1;
                            r_state <= ISSUE;
                        end else begin
                            gnt     <= '0;
                            r_ptr   <= w_next_ptr;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_color_cfg_scheduler.sv
//------------------------------------------------------------------------------
// Module  : tb_color_cfg_scheduler
// Brief   : Directed self-checking bench for color_cfg_scheduler (NREQ=2, TIMEOUT=15).
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_color_cfg_scheduler;

    logic       clk, rst;
    logic [1:0] req, lock;
    logic [7:0] req_addr, req_data;
    logic [1:0] gnt, done, err;
    logic [3:0] address, data;
    logic       valid, busy;
    logic       ack, ack_auto, ack_man, ack_en;
    int         ack_dly;
    int         n_checks, n_fail;

    assign ack = ack_en ? ack_auto : ack_man;

    color_cfg_scheduler #(
        .NREQ(2), .AW(4), .DW(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err),
        .address(address), .data(data), .valid(valid),
        .ack(ack), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Regfile model: raises ack ack_dly cycles after valid, drops it once valid falls
    initial begin
        int dcnt;
        dcnt     = 0;
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (!ack_en || !valid) begin
                ack_auto = 1'b0;
                dcnt     = 0;
            end else if (!ack_auto) begin
                if (dcnt >= ack_dly) ack_auto = 1'b1;
                else dcnt++;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; lock = '0; req_addr = '0; req_data = '0;
        ack_en = 1'b0; ack_man = 1'b0; ack_dly = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        n_checks++; if (done !== 2'b00 || err !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got done=%b err=%b expected 00/00", done, err); end
        n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid_busy: got %b/%b expected 0/0", valid, busy); end
        n_checks++; if (address !== 4'h0 || data !== 4'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", address, data); end
    endtask

    task automatic test_single_write();
        int  ndone;
        bit  unstable;
        apply_reset();
        ack_en = 1'b1; ack_dly = 3;
        @(negedge clk);
        req = 2'b01; req_addr[3:0] = 4'h3; req_data[3:0] = 4'hA;
        @(posedge clk); #1;
        n_checks++; if (gnt !== 2'b01 || valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: got gnt=%b valid=%b busy=%b expected 01/0/1", gnt, valid, busy); end
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b1 || address !== 4'h3 || data !== 4'hA) begin n_fail++; $display("FAIL single_latency: got valid=%b addr=%h data=%h expected 1/3/a", valid, address, data); end
        ndone = 0; unstable = 1'b0;
        for (int c = 0; c < 40 && ndone == 0; c++) begin
            @(negedge clk);
            if (valid && (address !== 4'h3 || data !== 4'hA)) unstable = 1'b1;
            if (done == 2'b01) begin ndone++; req = 2'b00; end
        end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL single_done: got %0d done pulses expected 1", ndone); end
        n_checks++; if (unstable !== 1'b0) begin n_fail++; $display("FAIL single_stable: got unstable=%b expected 0", unstable); end
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt_hold: got %b expected 01", gnt); end
        @(posedge clk); #1;
        n_checks++; if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin n_fail++; $display("FAIL single_release: got gnt=%b busy=%b done=%b expected 00/0/00", gnt, busy, done); end
    endtask

    task automatic test_contention();
        logic [1:0] seq [2];
        logic [1:0] last;
        int  n, served;
        bit  two_hot, v_no_g;
        apply_reset();
        ack_en = 1'b1; ack_dly = 1;
        @(negedge clk);
        req = 2'b11; req_addr = 8'h21; req_data = 8'h43;
        seq[0] = '0; seq[1] = '0; last = '0; n = 0; served = 0; two_hot = 1'b0; v_no_g = 1'b0;
        for (int c = 0; c < 100 && served < 2; c++) begin
            @(negedge clk);
            if ($countones(gnt) > 1) two_hot = 1'b1;
            if (valid && gnt == 2'b00) v_no_g = 1'b1;
            if (gnt != 2'b00 && last == 2'b00 && n < 2) begin seq[n] = gnt; n++; end
            last = gnt;
            if (done != 2'b00) begin served++; req = req & ~done; end
        end
        n_checks++; if (seq[0] !== 2'b01 || seq[1] !== 2'b10) begin n_fail++; $display("FAIL contention_order: got %b then %b expected 01 then 10", seq[0], seq[1]); end
        n_checks++; if (served !== 2) begin n_fail++; $display("FAIL contention_served: got %0d expected 2", served); end
        n_checks++; if (two_hot !== 1'b0 || v_no_g !== 1'b0) begin n_fail++; $display("FAIL contention_onehot: got two_hot=%b valid_no_gnt=%b expected 0/0", two_hot, v_no_g); end
    endtask

    task automatic test_locked_burst();
        logic [23:0] color;
        logic [3:0]  nib;
        int  k;
        bit  early0, gap, bad, got0;
        apply_reset();
        ack_en = 1'b1; ack_dly = 0;
        color = 24'hA5C3E7;
        @(negedge clk);
        req[1] = 1'b1; lock[1] = 1'b1; req_addr[7:4] = 4'h0; req_data[7:4] = color[3:0];
        @(negedge clk);
        req[0] = 1'b1; req_addr[3:0] = 4'hF; req_data[3:0] = 4'h5;
        k = 0; early0 = 1'b0; gap = 1'b0; bad = 1'b0; got0 = 1'b0;
        for (int c = 0; c < 200 && !got0; c++) begin
            @(negedge clk);
            if (gnt[0] && k < 6) early0 = 1'b1;
            if (gnt == 2'b00 && k > 0 && k < 6) gap = 1'b1;
            nib = color[k*4 +: 4];
            if (valid && gnt[1] && (address !== 4'(k) || data !== nib)) bad = 1'b1;
            if (done[1]) begin
                k++;
                if (k == 6) begin req[1] = 1'b0; lock[1] = 1'b0; end
                else begin req_addr[7:4] = 4'(k); req_data[7:4] = color[k*4 +: 4]; end
            end
            if (done[0]) begin got0 = 1'b1; req[0] = 1'b0; end
        end
        n_checks++; if (k !== 6) begin n_fail++; $display("FAIL burst_count: got %0d writes expected 6", k); end
        n_checks++; if (early0 !== 1'b0 || gap !== 1'b0) begin n_fail++; $display("FAIL burst_uninterrupted: got early0=%b gap=%b expected 0/0", early0, gap); end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL burst_addr_data: got bad=%b expected 0", bad); end
        n_checks++; if (got0 !== 1'b1) begin n_fail++; $display("FAIL burst_req0_after: got %b expected 1", got0); end
    endtask

    task automatic test_timeout();
        int vcnt, ecnt, dcnt, post;
        apply_reset();
        @(negedge clk);
        req = 2'b01; req_addr[3:0] = 4'h7; req_data[3:0] = 4'h1;
        vcnt = 0; ecnt = 0; dcnt = 0; post = -1;
        for (int c = 0; c < 80 && post != 0; c++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (err == 2'b01) begin ecnt++; req = 2'b00; post = 2; end
            else if (post > 0) post--;
            if (done != 2'b00) dcnt++;
        end
        n_checks++; if (vcnt !== 15) begin n_fail++; $display("FAIL timeout_valid_len: got %0d cycles expected 15", vcnt); end
        n_checks++; if (ecnt !== 1 || dcnt !== 0) begin n_fail++; $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1/0", ecnt, dcnt); end
        n_checks++; if (busy !== 1'b0 || gnt !== 2'b00) begin n_fail++; $display("FAIL timeout_idle: got busy=%b gnt=%b expected 0/00", busy, gnt); end
    endtask

    task automatic test_ack_timeout_tie();
        int vcnt, ecnt, dcnt, post;
        apply_reset();
        @(negedge clk);
        req = 2'b01;
        vcnt = 0; ecnt = 0; dcnt = 0; post = -1;
        for (int c = 0; c < 80 && post != 0; c++) begin
            @(negedge clk);
            if (valid) begin vcnt++; if (vcnt == 15) ack_man = 1'b1; end
            if (err != 2'b00) ecnt++;
            if (done == 2'b01) begin dcnt++; ack_man = 1'b0; req = 2'b00; post = 2; end
            else if (post > 0) post--;
        end
        n_checks++; if (dcnt !== 1 || ecnt !== 0) begin n_fail++; $display("FAIL tie_ack_wins: got done=%0d err=%0d expected 1/0", dcnt, ecnt); end
    endtask

    task automatic test_ack_early();
        apply_reset();
        ack_man = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL early_idle: got busy=%b valid=%b expected 0/0", busy, valid); end
        req = 2'b01; req_addr[3:0] = 4'h9; req_data[3:0] = 4'h6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b0 || gnt !== 2'b01) begin n_fail++; $display("FAIL early_issue_wait: got valid=%b gnt=%b expected 0/01", valid, gnt); end
        @(posedge clk); #1;
        n_checks++; if (valid !== 1'b1 || address !== 4'h9) begin n_fail++; $display("FAIL early_valid: got valid=%b addr=%h expected 1/9", valid, address); end
        @(posedge clk); #1;
        n_checks++; if (done !== 2'b01 || err !== 2'b00 || valid !== 1'b0) begin n_fail++; $display("FAIL early_done: got done=%b err=%b valid=%b expected 01/00/0", done, err, valid); end
        ack_man = 1'b0; req = 2'b00;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_release: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        int ndone;
        apply_reset();
        @(negedge clk);
        req = 2'b01; req_addr[3:0] = 4'hC; req_data[3:0] = 4'h2;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (valid !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async: got valid=%b gnt=%b busy=%b expected 0/00/0", valid, gnt, busy); end
        @(negedge clk);
        rst = 1'b0; ack_en = 1'b1; ack_dly = 1;
        ndone = 0;
        for (int c = 0; c < 40 && ndone == 0; c++) begin
            @(negedge clk);
            if (done == 2'b01) begin ndone++; req = 2'b00; end
        end
        n_checks++; if (ndone !== 1 || address !== 4'hC) begin n_fail++; $display("FAIL midrst_recover: got done=%0d addr=%h expected 1/c", ndone, address); end
    endtask

    task automatic test_starvation();
        int  w1, w1_at0;
        bit  got0;
        apply_reset();
        ack_en = 1'b1; ack_dly = 0;
        @(negedge clk);
        req[1] = 1'b1; lock[1] = 1'b1; req_addr = 8'h4D; req_data = 8'h8E;
        @(negedge clk);
        req[0] = 1'b1;
        w1 = 0; w1_at0 = -1; got0 = 1'b0;
        for (int c = 0; c < 400 && !(got0 && w1 == 12); c++) begin
            @(negedge clk);
            if (gnt[0] && w1_at0 < 0) w1_at0 = w1;
            if (done[1]) begin w1++; if (w1 == 12) begin req[1] = 1'b0; lock[1] = 1'b0; end end
            if (done[0]) begin got0 = 1'b1; req[0] = 1'b0; end
        end
        n_checks++; if (w1_at0 !== 8) begin n_fail++; $display("FAIL starve_bound: got %0d writes before req0 grant expected 8", w1_at0); end
        n_checks++; if (w1 !== 12 || got0 !== 1'b1) begin n_fail++; $display("FAIL starve_complete: got w1=%0d got0=%b expected 12/1", w1, got0); end
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; req_addr = '0; req_data = '0;
        ack_en = 1'b0; ack_man = 1'b0; ack_dly = 0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_single_write();
        test_contention();
        test_locked_burst();
        test_timeout();
        test_ack_timeout_tie();
        test_ack_early();
        test_reset_mid_write();
        test_starvation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
